// File: rtl/seq_divider32_if.sv
// ----------------------------------------------------------------------------
// seq_divider32_if
//   Request/response bundle between the ALU controller and the sequential
//   divider.
//
//   start        controller -> divider  one-cycle request pulse
//   div_in0      controller -> divider  dividend
//   div_in1      controller -> divider  divisor
//   busy         divider -> controller  operation in progress
//   done         divider -> controller  one-cycle completion strobe
//   quotient     divider -> controller  result quotient (held)
//   remainder    divider -> controller  result remainder (held)
//   div_by_zero  divider -> controller  last completed op had a zero divisor
// ----------------------------------------------------------------------------
interface seq_divider32_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] div_in0;
   logic [WIDTH-1:0] div_in1;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   // ALU controller side
   modport master (
      output start,
      output div_in0,
      output div_in1,
      input  busy,
      input  done,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   // Divider side
   modport slave (
      input  start,
      input  div_in0,
      input  div_in1,
      output busy,
      output done,
      output quotient,
      output remainder,
      output div_by_zero
   );
endinterface

// File: rtl/seq_divider32.sv
// ----------------------------------------------------------------------------
// seq_divider32
//   Multi-cycle unsigned restoring divider. One subtract-and-shift step per
//   clock through a single WIDTH+1-bit subtractor.
//
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts any operation in flight
//   div_io  slave side of seq_divider32_if:
//             start/div_in0/div_in1 in, busy/done/quotient/remainder/
//             div_by_zero out (all outputs registered)
//
//   Sequence: IDLE -> LOAD -> RUN (WIDTH steps) -> DONE. A zero divisor goes
//   straight from IDLE/DONE to DONE. A start in DONE is accepted like one in
//   IDLE so operations can run back to back.
// ----------------------------------------------------------------------------
module seq_divider32 #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   seq_divider32_if.slave div_io
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] shreg_q, shreg_d;     // dividend bits out, quotient bits in
   logic [WIDTH-1:0] divisor_q, divisor_d;
   // The partial remainder is always below the divisor, so its WIDTH+1-th bit
   // is structurally zero and only the low WIDTH bits are stored.
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept;
   logic             zero_div;
   logic             last_step;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             qbit;

   // start is only looked at when no operation is in flight
   assign accept    = ((state_q == StIdle) || (state_q == StDone)) && div_io.start;
   assign zero_div  = (div_io.div_in1 == '0);
   assign last_step = (state_q == StRun) && (cnt_q == CNT_W'(1));

   // Restoring step: bring in the next dividend bit and try to subtract.
   assign shifted = {prem_q, shreg_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor_q};
   assign qbit    = ~trial[WIDTH];

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (div_io.start) begin
               state_d = zero_div ? StDone : StLoad;
            end else begin
               state_d = StIdle;
            end
         end
         StLoad: state_d = StRun;
         StRun: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs, decoded from the next state so they leave a flop
   // ---------------------------------------------------------------------
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      unique case (state_d)
         StLoad, StRun: busy_d = 1'b1;
         StDone:        done_d = 1'b1;
         default:       ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------
   always_comb begin
      shreg_d   = shreg_q;
      divisor_d = divisor_q;
      prem_d    = prem_q;
      cnt_d     = cnt_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;

      if (accept) begin
         shreg_d   = div_io.div_in0;
         divisor_d = div_io.div_in1;
         prem_d    = '0;
         cnt_d     = CNT_W'(WIDTH);
         if (zero_div) begin
            // Zero divisor: all-ones quotient, dividend passes through.
            quot_d = '1;
            rem_d  = div_io.div_in0;
            dbz_d  = 1'b1;
         end
      end else if (state_q == StRun) begin
         prem_d  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
         shreg_d = {shreg_q[WIDTH-2:0], qbit};
         cnt_d   = cnt_q - CNT_W'(1);
         if (last_step) begin
            quot_d = {shreg_q[WIDTH-2:0], qbit};
            rem_d  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            dbz_d  = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Datapath and result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q   <= '0;
         divisor_q <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         divisor_q <= divisor_d;
         prem_q    <= prem_d;
         cnt_q     <= cnt_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign div_io.busy        = busy_q;
   assign div_io.done        = done_q;
   assign div_io.quotient    = quot_q;
   assign div_io.remainder   = rem_q;
   assign div_io.div_by_zero = dbz_q;

   // done and busy decode from different states of one register
   a_done_busy_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(done_q && busy_q));

endmodule

// File: tb/tb_seq_divider32.sv
module tb_seq_divider32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_divider32_if #(.WIDTH(32)) dif ();

   seq_divider32 #(
      .WIDTH(32),
      .CNT_W(6)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .div_io(dif)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Issue one operation from posedge+1 and wait for done.
   // lat counts edges after the accepting edge before done is seen.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output int lat, output int nbusy);
      dif.start   = 1'b1;
      dif.div_in0 = a;
      dif.div_in1 = b;
      @(posedge clk); #1;
      dif.start = 1'b0;
      lat   = 0;
      nbusy = 0;
      while (!dif.done && lat < 100) begin
         if (dif.busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      q = dif.quotient;
      r = dif.remainder;
      z = dif.div_by_zero;
   endtask

   logic [31:0] q, r;
   logic        z;
   int          lat, nbusy, ndone;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          lat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      dif.start   = 1'b0;
      dif.div_in0 = '0;
      dif.div_in1 = '0;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", dif.busy, 0);
      check_val("rst_done", dif.done, 0);
      check_val("rst_q", dif.quotient, 0);
      check_val("rst_r", dif.remainder, 0);
      check_val("rst_dbz", dif.div_by_zero, 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_val("idle_busy", dif.busy, 0);
      check_val("idle_done", dif.done, 0);
      check_val("idle_q", dif.quotient, 0);

      // Directed vectors: 33 busy cycles then done, or immediate done for /0
      vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
      vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33};
      vecs[2] = '{32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, 33};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 33};
      vecs[4] = '{32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0};
      vecs[5] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33};
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, q, r, z, lat, nbusy);
         check_val($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         check_val($sformatf("v%0d_nbusy", i), 64'(nbusy), 64'(vecs[i].lat));
         check_val($sformatf("v%0d_busy_at_done", i), dif.busy, 0);
         check_val($sformatf("v%0d_q", i), q, vecs[i].q);
         check_val($sformatf("v%0d_r", i), r, vecs[i].r);
         check_val($sformatf("v%0d_dbz", i), z, vecs[i].z);
         @(posedge clk); #1;
         check_val($sformatf("v%0d_done_once", i), dif.done, 0);
         check_val($sformatf("v%0d_hold_q", i), dif.quotient, vecs[i].q);
      end

      // Busy interference: re-start and operand churn while running
      dif.start   = 1'b1;
      dif.div_in0 = 32'd1000;
      dif.div_in1 = 32'd10;
      @(posedge clk); #1;
      dif.start = 1'b0;
      ndone = 0;
      for (int c = 1; c < 80; c++) begin
         if (dif.done) begin
            ndone++;
            check_val("intf_q", dif.quotient, 32'd100);
            check_val("intf_r", dif.remainder, 32'd0);
         end
         dif.start = (c == 10);
         if (c == 10) begin
            dif.div_in0 = 32'd77;
            dif.div_in1 = 32'd5;
         end else if (c < 33) begin
            dif.div_in0 = $urandom;
            dif.div_in1 = $urandom;
         end else begin
            dif.div_in0 = '0;
            dif.div_in1 = 32'd1;
         end
         @(posedge clk); #1;
      end
      dif.start = 1'b0;
      check_val("intf_ndone", 64'(ndone), 64'd1);

      // Back-to-back with start held high through DONE
      dif.start   = 1'b1;
      dif.div_in0 = 32'd50;
      dif.div_in1 = 32'd6;
      @(posedge clk); #1;
      lat = 0;
      while (!dif.done && lat < 100) begin @(posedge clk); #1; lat++; end
      check_val("b2b1_lat", 64'(lat), 64'd33);
      check_val("b2b1_q", dif.quotient, 32'd8);
      check_val("b2b1_r", dif.remainder, 32'd2);
      dif.div_in1 = 32'd7;
      @(posedge clk); #1;
      check_val("b2b2_busy", dif.busy, 1);
      lat = 1;
      while (!dif.done && lat < 100) begin @(posedge clk); #1; lat++; end
      dif.start = 1'b0;
      check_val("b2b2_lat", 64'(lat), 64'd34);
      check_val("b2b2_q", dif.quotient, 32'd7);
      check_val("b2b2_r", dif.remainder, 32'd1);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a run
      dif.start   = 1'b1;
      dif.div_in0 = 32'd1000;
      dif.div_in1 = 32'd3;
      @(posedge clk); #1;
      dif.start = 1'b0;
      repeat (14) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("mrst_busy", dif.busy, 0);
      check_val("mrst_done", dif.done, 0);
      check_val("mrst_q", dif.quotient, 0);
      check_val("mrst_r", dif.remainder, 0);
      check_val("mrst_dbz", dif.div_by_zero, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ndone = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (dif.done || dif.busy) ndone++;
      end
      check_val("mrst_no_done", 64'(ndone), 64'd0);

      // Random operands, checked against the division identity
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i % 16 == 0) b = '0;
         run_op(a, b, q, r, z, lat, nbusy);
         if (b == 0) begin
            check_val("rnd_z_q", q, 32'hFFFF_FFFF);
            check_val("rnd_z_r", r, a);
            check_val("rnd_z_dbz", z, 1);
         end else begin
            check_val("rnd_ident", 64'(q) * 64'(b) + 64'(r), 64'(a));
            check_val("rnd_rlt", 64'(r < b), 64'd1);
            check_val("rnd_dbz", z, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
